// File: rtl/riscv_instr_aligner.sv
// Realigns sequential word-aligned fetch words into a stream of 16/32-bit RISC-V
// instructions, tracking the PC of each and handling straddles and halfword redirects.
module riscv_instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        compressed,
    output logic [31:0] out_pc
);

    logic [15:0] hb_q [0:3];
    logic [15:0] hb_d [0:3];
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_lo_q, skip_lo_d;

    logic        head_c;
    logic        fire_out, fire_fetch;
    logic [2:0]  consumed, rem;
    logic [15:0] first_hw;

    assign head_c      = (hb_q[0][1:0] != 2'b11);
    assign fetch_ready = (cnt_q <= 3'd2);

    always_comb begin
        out_valid  = ((cnt_q >= 3'd1) && head_c) || (cnt_q >= 3'd2);
        compressed = 1'b0;
        instr      = '0;
        out_pc     = pc_q;
        // Empty buffer presents a clean zero instruction rather than stale halfwords.
        if (cnt_q != 3'd0) begin
            compressed = head_c;
            instr      = head_c ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
        end
    end

    assign fire_out   = out_valid && out_ready;
    assign fire_fetch = fetch_valid && fetch_ready;
    assign consumed   = fire_out ? (head_c ? 3'd1 : 3'd2) : 3'd0;
    assign rem        = cnt_q - consumed;
    assign first_hw   = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];

    always_comb begin
        case (consumed)
            3'd1:    hb_d = '{hb_q[1], hb_q[2], hb_q[3], 16'h0000};
            3'd2:    hb_d = '{hb_q[2], hb_q[3], 16'h0000, 16'h0000};
            default: hb_d = '{hb_q[0], hb_q[1], hb_q[2], hb_q[3]};
        endcase
        cnt_d     = rem;
        pc_d      = pc_q;
        skip_lo_d = skip_lo_q;

        if (fire_out) begin
            pc_d = pc_q + (head_c ? 32'd2 : 32'd4);
        end

        // fetch_ready guarantees rem <= 2 whenever a word is appended.
        if (fire_fetch) begin
            case (rem)
                3'd0:    hb_d[0] = first_hw;
                3'd1:    hb_d[1] = first_hw;
                default: hb_d[2] = first_hw;
            endcase
            if (!skip_lo_q) begin
                case (rem)
                    3'd0:    hb_d[1] = fetch_data[31:16];
                    3'd1:    hb_d[2] = fetch_data[31:16];
                    default: hb_d[3] = fetch_data[31:16];
                endcase
                cnt_d = rem + 3'd2;
            end else begin
                cnt_d = rem + 3'd1;
            end
            skip_lo_d = 1'b0;
        end

        if (flush) begin
            cnt_d     = '0;
            pc_d      = flush_pc & ~32'h0000_0001;
            skip_lo_d = flush_pc[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pc_q      <= RESET_PC;
            skip_lo_q <= RESET_PC[1];
            hb_q      <= '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        end else begin
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
            hb_q      <= hb_d;
        end
    end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Self-checking bench for riscv_instr_aligner: directed scenarios plus a randomized
// run compared against a halfword-queue reference model.
module tb_riscv_instr_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        compressed;
    logic [31:0] out_pc;

    int unsigned checks = 0;
    int unsigned errors = 0;

    riscv_instr_aligner #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .compressed  (compressed),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] fd, input logic ordy,
                         input logic fl, input logic [31:0] fpc);
        fetch_valid = fv;
        fetch_data  = fd;
        out_ready   = ordy;
        flush       = fl;
        flush_pc    = fpc;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0400);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr); end
        checks++; if (compressed !== 1'b0) begin errors++; $display("FAIL reset_comp got %0b want 0", compressed); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want 00000100", out_pc); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fready got %0b want 1", fetch_ready); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL single_instr got %h want 00a00093", instr); end
        checks++; if (compressed !== 1'b0) begin errors++; $display("FAIL single_comp got %0b want 0", compressed); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL single_pc got %h want 00000100", out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL single_nextpc got %h want 00000104", out_pc); end
    endtask

    task automatic test_compressed();
        do_reset();
        drive(1'b1, 32'h4501_4501, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (instr !== 32'h0000_4501 || compressed !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL c0_out got v=%0b i=%h c=%0b want v=1 i=00004501 c=1", out_valid, instr, compressed); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL c0_pc got %h want 00000100", out_pc); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL c0_fready got %0b want 1", fetch_ready); end
        cyc();
        checks++; if (instr !== 32'h0000_4501 || compressed !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL c1_out got v=%0b i=%h c=%0b want v=1 i=00004501 c=1", out_valid, instr, compressed); end
        checks++; if (out_pc !== 32'h102) begin errors++; $display("FAIL c1_pc got %h want 00000102", out_pc); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL c1_fready got %0b want 1", fetch_ready); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c2_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_straddle();
        do_reset();
        drive(1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b1 || instr !== 32'h0000_4501 || out_pc !== 32'h100) begin errors++; $display("FAIL st_cli got v=%0b i=%h pc=%h want v=1 i=00004501 pc=00000100", out_valid, instr, out_pc); end
        cyc();
        drive(1'b1, 32'h0000_00A0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_bubble got %0b want 0", out_valid); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL st_fready got %0b want 1", fetch_ready); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b1 || instr !== 32'h00A0_0093 || compressed !== 1'b0) begin errors++; $display("FAIL st_addi got v=%0b i=%h c=%0b want v=1 i=00a00093 c=0", out_valid, instr, compressed); end
        checks++; if (out_pc !== 32'h102) begin errors++; $display("FAIL st_pc got %h want 00000102", out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b1 || instr !== 32'h0 || compressed !== 1'b1 || out_pc !== 32'h106) begin errors++; $display("FAIL st_tail got v=%0b i=%h c=%0b pc=%h want v=1 i=00000000 c=1 pc=00000106", out_valid, instr, compressed, out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_0202);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre got %0b want 1", out_valid); end
        cyc();
        drive(1'b1, 32'h4505_0000, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h202) begin errors++; $display("FAIL fl_pc got %h want 00000202", out_pc); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b1 || instr !== 32'h0000_4505 || compressed !== 1'b1) begin errors++; $display("FAIL fl_out got v=%0b i=%h c=%0b want v=1 i=00004505 c=1", out_valid, instr, compressed); end
        checks++; if (out_pc !== 32'h202) begin errors++; $display("FAIL fl_outpc got %h want 00000202", out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h204) begin errors++; $display("FAIL fl_drain got v=%0b pc=%h want v=0 pc=00000204", out_valid, out_pc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_fready2 got %0b want 1", fetch_ready); end
        cyc();
        drive(1'b1, 32'h00B0_0113, 1'b0, 1'b0, 32'h0);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b want 0", fetch_ready); end
        for (int unsigned k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || instr !== 32'h00A0_0093 || out_pc !== 32'h100) begin errors++; $display("FAIL bp_hold%0d got v=%0b i=%h pc=%h want v=1 i=00a00093 pc=00000100", k, out_valid, instr, out_pc); end
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (instr !== 32'h00A0_0093 || out_pc !== 32'h100) begin errors++; $display("FAIL bp_d0 got i=%h pc=%h want i=00a00093 pc=00000100", instr, out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b1 || instr !== 32'h0000_4501 || out_pc !== 32'h104) begin errors++; $display("FAIL bp_d1 got v=%0b i=%h pc=%h want v=1 i=00004501 pc=00000104", out_valid, instr, out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b1 || instr !== 32'h0000_4501 || out_pc !== 32'h106) begin errors++; $display("FAIL bp_d2 got v=%0b i=%h pc=%h want v=1 i=00004501 pc=00000106", out_valid, instr, out_pc); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_d3 got %0b want 0", out_valid); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        drive(1'b1, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0);
        cyc();
        // Three halfwords buffered now; flush must override both handshakes.
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0300);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h102) begin errors++; $display("FAIL fp_pre got v=%0b pc=%h want v=1 pc=00000102", out_valid, out_pc); end
        cyc();
        drive(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h300 || fetch_ready !== 1'b1) begin errors++; $display("FAIL fp_post got v=%0b pc=%h fr=%0b want v=0 pc=00000300 fr=1", out_valid, out_pc, fetch_ready); end
        cyc();
        drive(1'b1, 32'h4501_4501, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b1 || instr !== 32'h00A0_0093 || out_pc !== 32'h300) begin errors++; $display("FAIL fp_new got v=%0b i=%h pc=%h want v=1 i=00a00093 pc=00000300", out_valid, instr, out_pc); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h100 || instr !== 32'h0) begin errors++; $display("FAIL fp_rst got v=%0b pc=%h i=%h want v=0 pc=00000100 i=00000000", out_valid, out_pc, instr); end
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    task automatic test_random(input int unsigned n);
        logic [15:0] q [$];
        logic [31:0] mpc;
        logic        mskip;
        logic        fv, ordy, fl, ev, efr, ec;
        logic [31:0] fd, fpc, ei;
        do_reset();
        q.delete();
        mpc   = 32'h100;
        mskip = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            fv   = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(2, 0) != 0);
            fl   = ($urandom_range(39, 0) == 0);
            fd   = {rand_hw(), rand_hw()};
            fpc  = $urandom;
            if ($urandom_range(3, 0) == 0) fpc = 32'hFFFF_FFF0 | (fpc & 32'hF);
            drive(fv, fd, ordy, fl, fpc);

            efr = (q.size() <= 2);
            ec  = (q.size() >= 1) && (q[0][1:0] != 2'b11);
            ev  = ec || (q.size() >= 2);
            ei  = 32'h0;
            if (ec) ei = {16'h0000, q[0]};
            else if (q.size() >= 2) ei = {q[1], q[0]};

            checks++; if (fetch_ready !== efr) begin errors++; $display("FAIL rnd_fready @%0d got %0b want %0b", k, fetch_ready, efr); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_valid @%0d got %0b want %0b", k, out_valid, ev); end
            checks++; if (out_pc !== mpc) begin errors++; $display("FAIL rnd_pc @%0d got %h want %h", k, out_pc, mpc); end
            if (ev || q.size() == 0) begin
                checks++; if (instr !== ei || compressed !== ec) begin errors++; $display("FAIL rnd_instr @%0d got %h/%0b want %h/%0b", k, instr, compressed, ei, ec); end
            end

            cyc();

            if (fl) begin
                q.delete();
                mpc   = fpc & ~32'h1;
                mskip = fpc[1];
            end else begin
                if (ev && ordy) begin
                    if (ec) begin void'(q.pop_front()); mpc = mpc + 32'd2; end
                    else begin void'(q.pop_front()); void'(q.pop_front()); mpc = mpc + 32'd4; end
                end
                if (fv && efr) begin
                    if (!mskip) q.push_back(fd[15:0]);
                    q.push_back(fd[31:16]);
                    mskip = 1'b0;
                end
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc();
        test_reset();
        test_single();
        test_compressed();
        test_straddle();
        test_flush();
        test_backpressure();
        test_flush_priority();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
